// File: rtl/filter_arbiter_if.sv
// Channel-side handshake bundle for filter_arbiter.
// Ports: ch_valid/ch_data from the sources, ch_ready back from the arbiter.
interface filter_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    logic [NCH-1:0]       ch_valid;
    logic [NCH*WIDTH-1:0] ch_data;
    logic [NCH-1:0]       ch_ready;

    modport master (
        output ch_valid,
        output ch_data,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_data,
        output ch_ready
    );
endinterface

// File: rtl/filter_arbiter.sv
// Round-robin arbiter sharing one pipelined filter among NCH channels.
// Ports: clk, rst (sync, active-high); ch (channel bundle, slave side);
//   flt_data/flt_valid -> filter, flt_result <- filter;
//   out_data/out_valid/out_ch tagged filter output; busy activity flag.
module filter_arbiter #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int TAPS  = 4,
    parameter int BURST = 4,
    parameter int LAT   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    filter_arbiter_if.slave          ch,
    output logic [WIDTH-1:0]         flt_data,
    output logic                     flt_valid,
    input  logic [WIDTH-1:0]         flt_result,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     busy
);
    localparam int IW = $clog2(NCH);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int FW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    logic          tv_q [LAT];
    logic [IW-1:0] tc_q [LAT];

    logic          cur_valid;
    logic          accept;
    logic          any_valid;
    logic          pick_hit;
    logic [IW-1:0] pick;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          pipe_any;
    logic [WIDTH-1:0] sel_data;

    assign cur_valid = ch.ch_valid[g_q];
    assign any_valid = |ch.ch_valid;
    assign accept    = (state_q == GRANT) && cur_valid;

    // Round-robin search: first requesting channel after last_q,
    // wrapping modulo NCH.
    always_comb begin
        pick     = '0;
        pick_hit = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            sum = {1'b0, last_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NCH)) begin
                sum = sum - (IW+1)'(NCH);
            end
            cand = sum[IW-1:0];
            if (!pick_hit && ch.ch_valid[cand]) begin
                pick     = cand;
                pick_hit = 1'b1;
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g_q == IW'(i)) begin
                sel_data = ch.ch_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ch.ch_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            ch.ch_ready[i] = (state_q == GRANT) && (g_q == IW'(i));
        end
    end

    assign flt_data  = (state_q == GRANT) ? sel_data : '0;
    assign flt_valid = (state_q == GRANT) ? cur_valid : 1'b0;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid && pick_hit) begin
                    g_d     = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!cur_valid) begin
                    // Source went quiet: give up the rest of the burst.
                    last_d  = g_q;
                    fcnt_d  = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BURST-1)) begin
                        last_d  = g_q;
                        fcnt_d  = '0;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Bubbles drain the shared delay line between owners.
                if (fcnt_q == FW'(TAPS-1)) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(NCH-1);
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Tag pipe tracks which accepted sample emerges from the filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tv_q[i] <= 1'b0;
                tc_q[i] <= '0;
            end
        end else begin
            tv_q[0] <= accept;
            tc_q[0] <= g_q;
            for (int i = 1; i < LAT; i++) begin
                tv_q[i] <= tv_q[i-1];
                tc_q[i] <= tc_q[i-1];
            end
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pipe_any = pipe_any | tv_q[i];
        end
    end

    assign out_data  = flt_result;
    assign out_valid = tv_q[LAT-1];
    assign out_ch    = tc_q[LAT-1];
    assign busy      = (state_q != IDLE) || pipe_any;

endmodule

// File: tb/tb_filter_arbiter.sv
// Bench for filter_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_filter_arbiter;
    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int TAPS  = 4;
    localparam int BURST = 4;
    localparam int LAT   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    filter_arbiter_if #(.WIDTH(WIDTH), .NCH(NCH)) chif ();

    logic [WIDTH-1:0] flt_data;
    logic             flt_valid;
    logic [WIDTH-1:0] flt_result = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [1:0]       out_ch;
    logic             busy;

    filter_arbiter #(
        .WIDTH(WIDTH), .NCH(NCH), .TAPS(TAPS),
        .BURST(BURST), .LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch        (chif),
        .flt_data  (flt_data),
        .flt_valid (flt_valid),
        .flt_result(flt_result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: current owner (-1 none), samples taken, flush cycles left.
    int m_owner = -1;
    int m_taken = 0;
    int m_gap   = 0;
    int m_last  = NCH-1;
    bit q_v[$];
    int q_c[$];
    bit chk_en = 1'b0;
    int cyc_n  = 0;

    int gl_cyc[$];
    int gl_ch[$];
    logic [NCH-1:0] prev_rdy = '0;
    int acc_vals[$];
    int acc_cnt = 0;
    int ov_cnt  = 0;
    int ov_ch   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [NCH-1:0]   er;
        logic [WIDTH-1:0] ed;
        logic ev, eb, acc;
        int ix, found;
        @(negedge clk);
        if (chk_en) begin
            er = '0;
            ed = '0;
            ev = 1'b0;
            if (m_owner >= 0) begin
                er[m_owner] = 1'b1;
                ev = chif.ch_valid[m_owner];
                ed = chif.ch_data[m_owner*WIDTH +: WIDTH];
            end
            eb = (m_owner >= 0) || (m_gap > 0);
            foreach (q_v[i]) if (q_v[i]) eb = 1'b1;
            chk("ch_ready", 32'(chif.ch_ready), 32'(er));
            chk("flt_valid", 32'(flt_valid), 32'(ev));
            chk("flt_data", 32'(flt_data), 32'(ed));
            chk("out_valid", 32'(out_valid), 32'(q_v[0]));
            chk("busy", 32'(busy), 32'(eb));
            chk("ready_onehot0", 32'($onehot0(chif.ch_ready)), 32'(1));
            if (q_v[0]) begin
                chk("out_ch", 32'(out_ch), 32'(q_c[0]));
                chk("out_data", 32'(out_data), 32'(flt_result));
            end
            if (m_owner < 0 && m_gap > 0) begin
                chk("flush_flt_valid", 32'(flt_valid), 32'(0));
            end
            if (chif.ch_ready != '0 && chif.ch_ready != prev_rdy) begin
                ix = 0;
                for (int i = 0; i < NCH; i++) if (chif.ch_ready[i]) ix = i;
                gl_cyc.push_back(cyc_n);
                gl_ch.push_back(ix);
            end
            prev_rdy = chif.ch_ready;
            if (out_valid) begin
                ov_cnt++;
                ov_ch = int'(out_ch);
            end
            if ((chif.ch_ready & chif.ch_valid) != '0) begin
                acc_cnt++;
                acc_vals.push_back(int'(flt_data));
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_owner = -1;
            m_taken = 0;
            m_gap   = 0;
            m_last  = NCH-1;
            q_v.delete();
            q_c.delete();
            repeat (LAT) begin
                q_v.push_back(1'b0);
                q_c.push_back(0);
            end
            chk_en   = 1'b1;
            prev_rdy = '0;
        end else if (chk_en) begin
            acc = (m_owner >= 0) && chif.ch_valid[m_owner];
            q_v.push_back(acc);
            q_c.push_back(acc ? m_owner : 0);
            void'(q_v.pop_front());
            void'(q_c.pop_front());
            if (m_owner >= 0) begin
                if (!acc || m_taken + 1 == BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_gap   = TAPS;
                end else begin
                    m_taken++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (chif.ch_valid != '0) begin
                found = -1;
                for (int k = 1; k <= NCH; k++) begin
                    if (found < 0 && chif.ch_valid[(m_last + k) % NCH])
                        found = (m_last + k) % NCH;
                end
                m_owner = found;
                m_taken = 0;
            end
        end
        flt_result = WIDTH'($urandom);
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int g0, a0, o0, c0;
    logic [WIDTH-1:0] d0;
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        chif.ch_valid = '0;
        chif.ch_data  = '0;

        // Reset state
        do_reset();
        chk("rst_ready", 32'(chif.ch_ready), 32'(0));
        chk("rst_flt_valid", 32'(flt_valid), 32'(0));
        chk("rst_flt_data", 32'(flt_data), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        // ch0 alone, data 1,2,3,...
        chif.ch_valid = 4'b0001;
        d0 = 1;
        g0 = gl_ch.size();
        a0 = acc_vals.size();
        o0 = ov_cnt;
        for (int i = 0; i < 24; i++) begin
            chif.ch_data = '0;
            chif.ch_data[WIDTH-1:0] = d0;
            c0 = acc_cnt;
            cyc();
            if (acc_cnt != c0) d0++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("ch0_sample", 32'(acc_vals.size() > a0 + i ?
                acc_vals[a0+i] : -1), 32'(i + 1));
        end
        chk("ch0_grants", 32'(gl_ch.size() - g0 >= 2), 32'(1));
        if (gl_ch.size() - g0 >= 2) begin
            chk("ch0_regrant", 32'(gl_ch[g0+1]), 32'(0));
            chk("ch0_spacing", 32'(gl_cyc[g0+1] - gl_cyc[g0]), 32'(9));
        end
        chk("ch0_out_pulses", 32'(ov_cnt - o0), 32'(8));

        // All four channels requesting
        do_reset();
        chif.ch_valid = 4'b1111;
        g0 = gl_ch.size();
        for (int i = 0; i < 40; i++) begin
            chif.ch_data = {$urandom, $urandom};
            cyc();
        end
        chk("rr_grant_cnt", 32'(gl_ch.size() - g0 >= 5), 32'(1));
        if (gl_ch.size() - g0 >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 32'(gl_ch[g0+i]), 32'(exp_ord[i]));
                if (i > 0)
                    chk("rr_spacing", 32'(gl_cyc[g0+i] - gl_cyc[g0+i-1]),
                        32'(9));
            end
        end

        // ch2 drops valid after two accepts
        do_reset();
        chif.ch_valid = 4'b0100;
        chif.ch_data  = {$urandom, $urandom};
        c0 = acc_cnt;
        o0 = ov_cnt;
        for (int i = 0; i < 10 && acc_cnt - c0 < 2; i++) cyc();
        chk("ch2_two_acc", 32'(acc_cnt - c0), 32'(2));
        chif.ch_valid = 4'b0000;
        repeat (12) cyc();
        chk("ch2_out_pulses", 32'(ov_cnt - o0), 32'(2));
        chk("ch2_out_ch", 32'(ov_ch), 32'(2));
        chif.ch_valid = 4'b0100;
        c0 = acc_cnt;
        repeat (9) cyc();
        chk("ch2_full_burst", 32'(acc_cnt - c0), 32'(BURST));

        // last_grant = 1, then ch1 and ch3 both request
        do_reset();
        chif.ch_valid = 4'b0010;
        g0 = gl_ch.size();
        repeat (5) cyc();
        chif.ch_valid = 4'b1010;
        repeat (16) cyc();
        chk("rr13_cnt", 32'(gl_ch.size() - g0 >= 3), 32'(1));
        if (gl_ch.size() - g0 >= 3) begin
            chk("rr13_first", 32'(gl_ch[g0]), 32'(1));
            chk("rr13_second", 32'(gl_ch[g0+1]), 32'(3));
            chk("rr13_third", 32'(gl_ch[g0+2]), 32'(1));
        end

        // Reset during the third accept of a burst
        do_reset();
        chif.ch_valid = 4'b0001;
        c0 = acc_cnt;
        for (int i = 0; i < 10 && acc_cnt - c0 < 2; i++) cyc();
        chk("mid_two_acc", 32'(acc_cnt - c0), 32'(2));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chif.ch_valid = 4'b0000;
        chk("mid_ready", 32'(chif.ch_ready), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        o0 = ov_cnt;
        repeat (10) cyc();
        chk("mid_no_out", 32'(ov_cnt - o0), 32'(0));

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            chif.ch_valid = NCH'($urandom) | NCH'($urandom);
            if ($urandom_range(0, 9) == 0) chif.ch_valid = '0;
            chif.ch_data = {$urandom, $urandom};
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the sample width of every data port.
REQ-002 Parameter NCH, default 4, SHALL set the number of requesting channels (range 2..16).
REQ-003 Parameter TAPS, default 4, SHALL set the shared filter delay-line depth and the flush length in cycles.
REQ-004 Parameter BURST, default 4, SHALL set the maximum samples accepted per grant.
REQ-005 Parameter LAT, default 5, SHALL set the filter input-to-output latency in cycles (TAPS+1 for the team filter).
REQ-006 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-007 Port rst, input, 1, SHALL be the reset; it is synchronous and active-high.
REQ-008 Port ch_valid, input, NCH, SHALL carry the per-channel sample-valid flags.
REQ-009 Port ch_data, input, NCH*WIDTH, SHALL carry channel i's sample on bits [i*WIDTH +: WIDTH].
REQ-010 Port ch_ready, output, NCH, SHALL carry the per-channel accept flags.
REQ-011 Port flt_data, output, WIDTH, SHALL drive the shared filter's sample input.
REQ-012 Port flt_valid, output, 1, SHALL drive the shared filter's valid input.
REQ-013 Port flt_result, input, WIDTH, SHALL receive the shared filter's data output.
REQ-014 Port out_data, output, WIDTH, SHALL equal flt_result, qualified by out_valid.
REQ-015 Port out_valid, output, 1, SHALL mark an out_data sample that belongs to a real accepted input.
REQ-016 Port out_ch, output, $clog2(NCH), SHALL carry the channel index of the current out_data.
REQ-017 Port busy, output, 1, SHALL be high whenever the state is not IDLE or any tag-pipe entry is valid.

Function
REQ-018 The block SHALL implement the states IDLE, GRANT and FLUSH.
REQ-019 A sample SHALL be accepted in a cycle only when ch_valid[g] and ch_ready[g] are both high.
REQ-020 ch_ready[i] SHALL be high only in GRANT with grant index g == i; at most one bit is high, driven combinationally from the registered state.
REQ-021 In IDLE, if any ch_valid bit is high, the block SHALL select the first set channel searching upward from last_grant+1 (modulo NCH), load g, clear the burst counter and enter GRANT the next cycle.
REQ-022 In IDLE, with no ch_valid bit high, the block SHALL remain in IDLE.
REQ-023 In GRANT, flt_data SHALL equal ch_data[g] and flt_valid SHALL equal ch_valid[g]; both are combinational (zero latency).
REQ-024 In GRANT, each accept SHALL increment the burst counter.
REQ-025 An accept at counter value BURST-1 SHALL set last_grant=g and move the state to FLUSH.
REQ-026 If ch_valid[g] is low in any GRANT cycle, the block SHALL set last_grant=g and enter FLUSH; no sample is accepted that cycle.
REQ-027 In FLUSH, flt_data SHALL be 0, flt_valid SHALL be 0 and all ch_ready bits SHALL be 0 for exactly TAPS cycles, then the state SHALL return to IDLE.
REQ-028 Outside GRANT, flt_data and flt_valid SHALL be 0.
REQ-029 The block SHALL keep a LAT-deep tag pipe, each entry holding {valid, channel}; every cycle it SHALL shift in {accept, g}.
REQ-030 out_valid and out_ch SHALL come from the pipe's last entry, so out_valid rises exactly LAT cycles after the matching accept.
REQ-031 Grants SHALL rotate round-robin; a channel holding valid continuously SHALL wait at most NCH-1 grants.
REQ-032 The minimum spacing between grants SHALL be TAPS+1 cycles, counting FLUSH plus the IDLE cycle.

Reset
REQ-033 While rst is high at a clock edge, the block SHALL set the state to IDLE, last_grant to NCH-1, g to 0, the burst counter to 0 and every tag-pipe entry to 0.
REQ-034 The registered state of REQ-033 SHALL make ch_ready=0, flt_valid=0, flt_data=0, out_valid=0, out_ch=0 and busy=0 on the first cycle after reset.
REQ-035 Reset asserted mid-GRANT or mid-FLUSH SHALL take effect at that edge, discarding in-flight tags; no out_valid pulse SHALL follow from pre-reset accepts.

Verification
REQ-036 Bench: after reset, ch_valid=4'b0001 held, ch0 data 1,2,3,4,5 -> ch_ready[0] high 4 cycles, samples 1..4 accepted, then FLUSH 4 cycles, IDLE, regrant ch0; out_valid pulses 5 cycles after each accept with out_ch=0.
REQ-037 Bench: ch_valid=4'b1111 held -> grant order ch0,ch1,ch2,ch3,ch0, each 4 samples, 9-cycle grant-to-grant spacing.
REQ-038 Bench: ch2 alone, valid dropped after 2 accepts -> immediate FLUSH, burst counter cleared on next grant, only 2 out_valid pulses with out_ch=2.
REQ-039 Bench: ch1 and ch3 valid, last_grant=1 -> ch3 granted before ch1.
REQ-040 Bench: rst pulsed 1 cycle during the 3rd accepted sample of a burst -> next cycle IDLE, ch_ready=0, no out_valid for the 3 pre-reset samples.
REQ-041 Bench: every cycle, assert ch_ready is one-hot or zero, and flt_valid==0 in FLUSH.
